// File: rtl/sha_pad.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks with the 0x80
// marker, zero fill and the big-endian bit-length field, one buffer byte per cycle.
module sha_pad #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [511:0] out_block,
    output logic         out_first,
    output logic         out_last,
    input  logic         out_ready
);

    localparam logic [2:0] S_FILL = 3'd0;
    localparam logic [2:0] S_MARK = 3'd1;
    localparam logic [2:0] S_ZERO = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [2:0]       resume_reg, resume_next;
    logic [5:0]       idx_reg, idx_next;
    logic             ovf_reg, ovf_next;
    logic             first_reg, first_next;
    logic             last_reg, last_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             wr_en;
    logic [7:0]       wr_byte;
    logic [LEN_W-1:0] bit_len;
    logic [63:0]      len_field;
    logic [7:0]       buf_reg [64];

    assign bit_len   = cnt_reg << 3;
    assign len_field = 64'(bit_len);

    assign in_ready  = (state_reg == S_FILL);
    assign out_valid = (state_reg == S_OUT);
    assign out_first = first_reg;
    assign out_last  = last_reg;

    always_comb begin
        state_next  = state_reg;
        resume_next = resume_reg;
        ovf_next    = ovf_reg;
        first_next  = first_reg;
        last_next   = last_reg;
        cnt_next    = cnt_reg;
        wr_en       = 1'b0;
        wr_byte     = 8'h00;
        case (state_reg)
            S_FILL: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_byte  = in_data;
                    cnt_next = cnt_reg + 1'b1;
                    if (idx_reg == 6'd63) begin
                        state_next  = S_OUT;
                        last_next   = 1'b0;
                        resume_next = in_last ? S_MARK : S_FILL;
                    end else if (in_last) begin
                        state_next = S_MARK;
                    end
                end
            end
            S_MARK: begin
                wr_en   = 1'b1;
                wr_byte = 8'h80;
                if (idx_reg < 6'd55) begin
                    state_next = S_ZERO;
                end else if (idx_reg == 6'd55) begin
                    state_next = S_LEN;
                end else if (idx_reg == 6'd63) begin
                    // Marker filled the block exactly: the zero run starts in the next block.
                    state_next  = S_OUT;
                    last_next   = 1'b0;
                    resume_next = S_ZERO;
                end else begin
                    state_next = S_ZERO;
                    ovf_next   = 1'b1;
                end
            end
            S_ZERO: begin
                wr_en = 1'b1;
                if (ovf_reg && idx_reg == 6'd63) begin
                    state_next  = S_OUT;
                    last_next   = 1'b0;
                    resume_next = S_ZERO;
                    ovf_next    = 1'b0;
                end else if (!ovf_reg && idx_reg == 6'd55) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                wr_en   = 1'b1;
                wr_byte = len_field[{~idx_reg[2:0], 3'b000} +: 8];
                if (idx_reg == 6'd63) begin
                    state_next = S_OUT;
                    last_next  = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_reg) begin
                        state_next = S_FILL;
                        cnt_next   = '0;
                        first_next = 1'b1;
                        last_next  = 1'b0;
                    end else begin
                        state_next = resume_reg;
                        first_next = 1'b0;
                    end
                end
            end
            default: state_next = S_FILL;
        endcase
        idx_next = wr_en ? idx_reg + 6'd1 : idx_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_FILL;
            resume_reg <= S_FILL;
            idx_reg    <= '0;
            ovf_reg    <= 1'b0;
            first_reg  <= 1'b1;
            last_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            resume_reg <= resume_next;
            idx_reg    <= idx_next;
            ovf_reg    <= ovf_next;
            first_reg  <= first_next;
            last_reg   <= last_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Byte lanes of the block buffer; index 0 sits in the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_byte
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_reg[gi] <= 8'h00;
                end else if (wr_en && idx_reg == 6'(gi)) begin
                    buf_reg[gi] <= wr_byte;
                end
            end
            assign out_block[(63-gi)*8 +: 8] = buf_reg[gi];
        end
    endgenerate

endmodule

// File: doc/sha_pad.md
SHA_PAD -- requirements
Module: sha_pad

Interface
REQ-001 Parameter LEN_W, default 64, width of the bit-length counter and of the appended length field (SHA-256 requires 64).
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  byte offered.
REQ-006 in_data  in  8  message byte.
REQ-007 in_last  in  1  qualifies in_data as the final byte of the message.
REQ-008 in_ready  out  1  byte accepted on clk when in_valid && in_ready.
REQ-009 out_valid  out  1  padded 512-bit block available.
REQ-010 out_block  out  512  block; byte index 0 at [511:504], index 63 at [7:0].
REQ-011 out_first  out  1  block is the first block of its message.
REQ-012 out_last  out  1  block is the final block, containing the length field.
REQ-013 out_ready  in  1  downstream SHA core takes the block on clk when out_valid && out_ready.

Function
REQ-014 FSM states: FILL, MARK, ZERO, LEN, OUT; one buffer byte is written per cycle at index idx (6 bits).
REQ-015 FILL: in_ready=1; an accepted byte is written at idx, idx increments, and the byte counter increments.
REQ-016 FILL with an accepted byte at idx=63: next state OUT, out_last=0, and idx is 0 for the following block.
REQ-017 FILL with an accepted byte having in_last=1 and idx<63: next state MARK.
REQ-018 FILL with an accepted byte having in_last=1 and idx=63: next state OUT (out_last=0), and the pending flag is set so the next block starts in MARK.
REQ-019 MARK: writes 0x80 at idx. Next state is ZERO if idx<55, LEN if idx=55, and ZERO with the overflow flag set if idx>55.
REQ-020 ZERO: writes 0x00 at idx. Without overflow it stops after index 55 and enters LEN. With overflow it stops after index 63 and enters OUT (out_last=0), then continues ZERO from index 0 of the next block.
REQ-021 LEN: writes bytes 56..63 with the 64-bit big-endian bit length (byte count * 8), then enters OUT with out_last=1.
REQ-022 OUT: out_valid=1 starting the cycle after index 63 is written; out_block, out_first and out_last stay stable until out_ready is sampled high.
REQ-023 OUT handshake: on the handshake cycle, out_valid deasserts on the next cycle and the FSM resumes at FILL, MARK or ZERO according to the pending state.
REQ-024 After the out_last handshake: the byte counter clears, out_first rearms, and the FSM returns to FILL.
REQ-025 in_ready=0 in every state except FILL, so bytes are never dropped or duplicated under backpressure.
REQ-026 out_first=1 only for the first block emitted after reset or after the previous message's out_last handshake.
REQ-027 The bit-length counter wraps modulo 2^LEN_W without any error indication.
REQ-028 Messages have length >=1 byte; zero-length messages are not supported.
REQ-029 in_last asserted while in_valid=0 is ignored.
REQ-030 Latency: a 3-byte message accepted in cycles 0-2 asserts out_valid in cycle 64 (1 MARK + 52 ZERO + 8 LEN cycles).

Reset
REQ-031 rst=1 at a clock edge forces, on the next cycle: state FILL, idx=0, byte counter 0, overflow and pending flags cleared, out_valid=0, out_first=1, out_last=0, and out_block=0.
REQ-032 in_ready=1 in the first cycle after rst deasserts.
REQ-033 Reset mid-message or during OUT discards the partial block without emitting it, and the next accepted byte starts a new message.

Verification
REQ-034 "abc" (0x61,0x62,0x63 with last) -> one block 0x61626380, zeros, length 0x...0018; first=1, last=1; out_valid in cycle 64.
REQ-035 55-byte message -> one block: byte 55 = 0x80, length 0x1B8, last=1.
REQ-036 56-byte message -> two blocks: block 1 has 0x80 at index 56 and zeros to 63 (first=1, last=0); block 2 is zeros plus length 0x1C0 (first=0, last=1).
REQ-037 64-byte message -> two blocks: block 2 = 0x80, zeros, length 0x200.
REQ-038 "abc" with out_ready held low 20 cycles -> block and flags stable, in_ready=0 throughout, single handshake, then a new message is accepted immediately.
REQ-039 rst pulsed after 30 bytes of a message -> no block emitted; a subsequent "abc" produces exactly the REQ-034 block with out_first=1.
